// File: rtl/cam_gray_window.sv
// cam_gray_window: RGB -> 8-bit luma, then a sliding 3x3 luma window built
// from two line buffers. Byte k of win_o is row r = k/3 (0 = oldest line),
// column c = k%3 (0 = leftmost); the centre byte is pixel (x-1, y-1).
module cam_gray_window #(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic        frame_start_i,
  input  logic        pix_valid_i,
  input  logic [7:0]  cam_red_i,
  input  logic [7:0]  cam_green_i,
  input  logic [7:0]  cam_blue_i,
  output logic [71:0] win_o,
  output logic        win_valid_o,
  output logic        frame_done_o
);

  localparam int unsigned XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [XW-1:0] X_TWO  = XW'(2);
  localparam logic [YW-1:0] Y_TWO  = YW'(2);

  // ---------------------------------------------------------------------
  // Stage 1: luma and pixel position
  // ---------------------------------------------------------------------
  logic [15:0]   luma_sum;
  logic [7:0]    luma;

  // x_q/y_q hold the position the next accepted input pixel will take;
  // gx_q/gy_q travel with gray_q so stage 2 sees the position of its pixel.
  // Tracking position at the input (rather than at gray_v) lets a
  // frame_start coincident with a pixel tag that very pixel as (0,0).
  logic [XW-1:0] x_q, x_d, cur_x;
  logic [YW-1:0] y_q, y_d, cur_y;
  logic [XW-1:0] gx_q;
  logic [YW-1:0] gy_q;
  logic [7:0]    gray_q;
  logic          gray_v_q;

  // Weighted luma sum; coefficients total 256 so the sum never exceeds 16 bits
  always_comb begin
    luma_sum = 16'd77  * {8'd0, cam_red_i}
             + 16'd150 * {8'd0, cam_green_i}
             + 16'd29  * {8'd0, cam_blue_i};
    luma     = 8'(luma_sum >> 8);
  end

  // Next input position: frame_start restarts at (0,0), pixels advance raster order
  always_comb begin
    cur_x = frame_start_i ? '0 : x_q;
    cur_y = frame_start_i ? '0 : y_q;
    x_d   = cur_x;
    y_d   = cur_y;
    if (pix_valid_i) begin
      if (cur_x == X_LAST) begin
        x_d = '0;
        y_d = (cur_y == Y_LAST) ? '0 : cur_y + 1'b1;
      end else begin
        x_d = cur_x + 1'b1;
      end
    end
  end

  // Stage-1 registers: luma value, its position and its valid flag
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      x_q      <= '0;
      y_q      <= '0;
      gx_q     <= '0;
      gy_q     <= '0;
      gray_q   <= '0;
      gray_v_q <= 1'b0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      gray_v_q <= pix_valid_i;
      if (pix_valid_i) begin
        gray_q <= luma;
        gx_q   <= cur_x;
        gy_q   <= cur_y;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: line buffers and 3x3 window
  // ---------------------------------------------------------------------
  logic [7:0]  lb0_q [IMG_W];   // previous line (y-1)
  logic [7:0]  lb1_q [IMG_W];   // line before that (y-2)
  logic [7:0]  lb_rd0;
  logic [7:0]  lb_rd1;
  logic [23:0] col_new;
  logic [71:0] win_q, win_d;
  logic        win_valid_q;
  logic        frame_done_q;

  // Asynchronous read of both line buffers at the current column
  always_comb begin
    lb_rd0  = lb0_q[gx_q];
    lb_rd1  = lb1_q[gx_q];
    col_new = {gray_q, lb_rd0, lb_rd1};
  end

  // Line buffers roll down one line per accepted pixel; read happens before write
  always_ff @(posedge sys_clk_i) begin
    if (gray_v_q) begin
      lb1_q[gx_q] <= lb0_q[gx_q];
      lb0_q[gx_q] <= gray_q;
    end
  end

  // Window shifted one column left with the new column entering on the right
  always_comb begin
    win_d = win_q;
    for (int unsigned r = 0; r < 3; r++) begin
      win_d[24*r      +: 8] = win_q[24*r + 8  +: 8];
      win_d[24*r + 8  +: 8] = win_q[24*r + 16 +: 8];
      win_d[24*r + 16 +: 8] = col_new[8*r +: 8];
    end
  end

  // Window and status registers; they hold on input gaps, strobes drop to 0
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      win_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      win_valid_q  <= gray_v_q && (gx_q >= X_TWO) && (gy_q >= Y_TWO);
      frame_done_q <= gray_v_q && (gx_q == X_LAST) && (gy_q == Y_LAST);
      if (gray_v_q) begin
        win_q <= win_d;
      end
    end
  end

  assign win_o        = win_q;
  assign win_valid_o  = win_valid_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_cam_gray_window.sv
// Directed bench for cam_gray_window on a 4x4 image.
module tb_cam_gray_window;

  localparam int unsigned W = 4;
  localparam int unsigned H = 4;

  logic        clk;
  logic        rst_n;
  logic        frame_start;
  logic        pix_valid;
  logic [7:0]  red, green, blue;
  logic [71:0] win;
  logic        win_valid;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pix_cyc  = 0;   // cycle stamp of the most recently sent pixel
  int pix22    = 0;   // stamp of pixel (2,2) in the latest frame

  typedef struct {
    int          cyc;
    logic [71:0] win;
    logic        fd;
  } win_t;
  win_t wq[$];

  cam_gray_window #(.IMG_W(W), .IMG_H(H)) dut (
    .sys_clk_i    (clk),
    .sys_rst_i    (rst_n),
    .frame_start_i(frame_start),
    .pix_valid_i  (pix_valid),
    .cam_red_i    (red),
    .cam_green_i  (green),
    .cam_blue_i   (blue),
    .win_o        (win),
    .win_valid_o  (win_valid),
    .frame_done_o (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (win_valid) wq.push_back('{cyc, win, frame_done});
  end

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                      input logic fs);
    red = r; green = g; blue = b; frame_start = fs; pix_valid = 1'b1;
    @(posedge clk); #1;
    pix_cyc     = cyc;
    pix_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Grey frame with pixel value ofs + 10y + x; optional one-cycle gap after each pixel
  task automatic send_frame(input int ofs, input logic fs, input logic gap);
    for (int y = 0; y < int'(H); y++) begin
      for (int x = 0; x < int'(W); x++) begin
        logic [7:0] v;
        v = 8'(ofs + 10*y + x);
        send(v, v, v, fs && x == 0 && y == 0);
        if (x == 2 && y == 2) pix22 = pix_cyc;
        if (gap) idle(1);
      end
    end
  endtask

  function automatic logic [71:0] exp_win(input int ofs, input int x, input int y);
    logic [71:0] e;
    e = '0;
    for (int k = 0; k < 9; k++) e[8*k +: 8] = 8'(ofs + 10*(y - 2 + k/3) + (x - 2 + k%3));
    return e;
  endfunction

  // Four windows of one 4x4 frame, frame_done only on the last
  task automatic check_windows(input string tag, input int ofs, input int base);
    for (int i = 0; i < 4; i++) begin
      if (base + i < wq.size()) begin
        check({tag, "_win"}, wq[base+i].win, exp_win(ofs, 2 + i%2, 2 + i/2));
        check({tag, "_fd"}, 72'(wq[base+i].fd), 72'(i == 3));
      end
    end
  endtask

  function automatic int count_fd();
    int n;
    n = 0;
    foreach (wq[i]) if (wq[i].fd) n++;
    return n;
  endfunction

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; pix_valid = 1'b0;
    red = '0; green = '0; blue = '0;

    // reset state
    #12;
    check("rst_win", win, '0);
    check("rst_valid", 72'(win_valid), 72'(0));
    check("rst_done", 72'(frame_done), 72'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // luma coefficients, observed as window byte 8 at (2,2),(3,2),(2,3),(3,3)
    wq.delete();
    for (int y = 0; y < int'(H); y++) begin
      for (int x = 0; x < int'(W); x++) begin
        if      (x == 2 && y == 2) send(8'd255, 8'd255, 8'd255, 1'b0);
        else if (x == 3 && y == 2) send(8'd255, 8'd0,   8'd0,   1'b0);
        else if (x == 2 && y == 3) send(8'd0,   8'd255, 8'd0,   1'b0);
        else if (x == 3 && y == 3) send(8'd0,   8'd0,   8'd255, 1'b0);
        else                       send(8'd0,   8'd0,   8'd0,   x == 0 && y == 0);
      end
    end
    idle(4);
    check("luma_count", 72'(wq.size()), 72'(4));
    if (wq.size() >= 4) begin
      check("luma_white", 72'(wq[0].win[71:64]), 72'(255));
      check("luma_red",   72'(wq[1].win[71:64]), 72'(76));
      check("luma_green", 72'(wq[2].win[71:64]), 72'(149));
      check("luma_blue",  72'(wq[3].win[71:64]), 72'(28));
    end

    // window contents and latency, contiguous pixels
    wq.delete();
    send_frame(0, 1'b1, 1'b0);
    idle(4);
    check("win_count", 72'(wq.size()), 72'(4));
    check_windows("win", 0, 0);
    if (wq.size() > 0) check("win_latency", 72'(wq[0].cyc), 72'(pix22 + 1));

    // same frame with a bubble after every pixel
    wq.delete();
    send_frame(0, 1'b1, 1'b1);
    idle(4);
    check("bub_count", 72'(wq.size()), 72'(4));
    check_windows("bub", 0, 0);
    foreach (wq[i]) check("bub_phase", 72'((wq[i].cyc - pix22 - 1) % 2), 72'(0));
    check("bub_fd_count", 72'(count_fd()), 72'(4 - 3));

    // frame restart at pixel (1,2)
    wq.delete();
    for (int n = 0; n < 9; n++) send(8'(n), 8'(n), 8'(n), n == 0);
    send_frame(100, 1'b1, 1'b0);
    idle(4);
    check("rs_count", 72'(wq.size()), 72'(4));
    check_windows("rs", 100, 0);
    if (wq.size() > 0) check("rs_first", 72'(wq[0].cyc), 72'(pix22 + 1));

    // asynchronous reset mid-frame, then a frame without frame_start
    for (int n = 0; n < 9; n++) begin
      logic [7:0] v;
      v = 8'(10*(n/4) + n%4 + 1);
      send(v, v, v, n == 0);
    end
    #2 rst_n = 1'b0;
    #1;
    check("mrst_win", win, '0);
    check("mrst_valid", 72'(win_valid), 72'(0));
    check("mrst_done", 72'(frame_done), 72'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    wq.delete();
    send_frame(50, 1'b0, 1'b0);
    idle(4);
    check("mrst_count", 72'(wq.size()), 72'(4));
    check_windows("mrst", 50, 0);

    // two frames back to back, wrapping without frame_start
    wq.delete();
    send_frame(0, 1'b0, 1'b0);
    send_frame(60, 1'b0, 1'b0);
    idle(4);
    check("b2b_count", 72'(wq.size()), 72'(8));
    check_windows("b2b_f1", 0, 0);
    check_windows("b2b_f2", 60, 4);
    check("b2b_fd_count", 72'(count_fd()), 72'(2));
    if (wq.size() >= 8) check("b2b_fd_gap", 72'(wq[7].cyc - wq[3].cyc), 72'(16));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
